// File: rtl/branch_pkg.sv
// branch_pkg: shared opcodes, stage/update records and FSM states for branch resolution.
package branch_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic pred_taken;
    logic [XLEN-1:0] pred_target;
  } pred_stage_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic taken;
    logic uncond;
  } btb_update_t;
  typedef enum logic {NORMAL, RECOVER} bru_state_t;
endpackage

// File: rtl/branch_resolution_unit_if.sv
// branch_resolution_unit_if: fetch, execute and BTB-update signals of the branch resolution unit.
interface branch_resolution_unit_if #(parameter int DATA_WIDTH = 32);
  logic valid_f, predict_taken_f, stall, is_cond_e, is_jal_e, actual_taken_e;
  logic [DATA_WIDTH-1:0] PC_f, predict_target_f, actual_target_e;
  logic mispredict, flush, recovering, upd_valid, upd_taken, upd_uncond;
  logic [DATA_WIDTH-1:0] redirect_pc, upd_pc, upd_target, branch_count, mispredict_count;
  modport master (
    output valid_f, PC_f, predict_taken_f, predict_target_f, stall,
           is_cond_e, is_jal_e, actual_taken_e, actual_target_e,
    input  mispredict, redirect_pc, flush, recovering, upd_valid, upd_pc,
           upd_target, upd_taken, upd_uncond, branch_count, mispredict_count
  );
  modport slave (
    input  valid_f, PC_f, predict_taken_f, predict_target_f, stall,
           is_cond_e, is_jal_e, actual_taken_e, actual_target_e,
    output mispredict, redirect_pc, flush, recovering, upd_valid, upd_pc,
           upd_target, upd_taken, upd_uncond, branch_count, mispredict_count
  );
endinterface

// File: rtl/pred_pipe_reg.sv
// pred_pipe_reg: one prediction pipeline stage; flush beats hold, hold beats bubble.
module pred_pipe_reg
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic        flush,
  input  pred_stage_t d,
  output pred_stage_t q
);
  pred_stage_t q_d, q_q;
  always_comb begin
    q_d = hold ? q_q : d;
    q_d.valid = !flush && (hold ? q_q.valid : (d.valid && !bubble));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: carries fetch predictions to execute, detects mispredicts,
// drives redirect/flush, a registered BTB update port and performance counters.
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int RECOVER_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  branch_resolution_unit_if.slave io
);
  localparam int CW = $clog2(RECOVER_CYCLES) + 1;
  pred_stage_t f_stage, d_stage, e_stage;
  bru_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  btb_update_t upd_q, upd_d;
  logic [DATA_WIDTH-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic [DATA_WIDTH-1:0] seq_pc;
  logic active, mispredict;
  assign f_stage = '{valid: io.valid_f, pc: io.PC_f, pred_taken: io.predict_taken_f,
                     pred_target: io.predict_target_f};
  pred_pipe_reg u_d (.clk(clk), .rst(rst), .hold(io.stall), .bubble(1'b0),
                     .flush(mispredict), .d(f_stage), .q(d_stage));
  pred_pipe_reg u_e (.clk(clk), .rst(rst), .hold(1'b0), .bubble(io.stall),
                     .flush(mispredict), .d(d_stage), .q(e_stage));
  always_comb begin
    active = e_stage.valid && (io.is_cond_e || io.is_jal_e) && state_q == NORMAL;
    mispredict = active && (e_stage.pred_taken != io.actual_taken_e ||
                 (e_stage.pred_taken && io.actual_taken_e && e_stage.pred_target != io.actual_target_e));
    seq_pc = e_stage.pc + DATA_WIDTH'(4);
    state_d = state_q == NORMAL ? (mispredict ? RECOVER : NORMAL) : (cnt_q == '0 ? NORMAL : RECOVER);
    cnt_d = state_q == NORMAL ? (mispredict ? CW'(RECOVER_CYCLES - 1) : cnt_q)
                              : (cnt_q == '0 ? cnt_q : cnt_q - CW'(1));
    // Fields hold between resolutions so the BTB sees the last write when idle.
    upd_d = upd_q;
    upd_d.valid = active;
    if (active) begin
      upd_d.pc = e_stage.pc;
      upd_d.target = io.actual_target_e;
      upd_d.taken = io.actual_taken_e;
      upd_d.uncond = io.is_jal_e;
    end
    branch_count_d = branch_count_q + (active ? DATA_WIDTH'(1) : '0);
    mispredict_count_d = mispredict_count_q + (mispredict ? DATA_WIDTH'(1) : '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= NORMAL;
      cnt_q <= '0;
      upd_q <= '0;
      branch_count_q <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      upd_q <= upd_d;
      branch_count_q <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  assign io.mispredict = mispredict;
  assign io.flush = mispredict;
  assign io.redirect_pc = (mispredict && io.actual_taken_e) ? io.actual_target_e : seq_pc;
  assign io.recovering = state_q == RECOVER;
  assign io.upd_valid = upd_q.valid;
  assign io.upd_pc = upd_q.pc;
  assign io.upd_target = upd_q.target;
  assign io.upd_taken = upd_q.taken;
  assign io.upd_uncond = upd_q.uncond;
  assign io.branch_count = branch_count_q;
  assign io.mispredict_count = mispredict_count_q;
endmodule
